// File: rtl/spi_slave_ctrl.sv
// SPI slave transaction controller: turns each received SPI command word into one
// valid/ready bus access and loads the response word for the next frame.
module spi_slave_ctrl #(
    parameter int SPI_DATA_W = 32,
    parameter int ADDR_W     = 7,
    parameter int TIMEOUT    = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [SPI_DATA_W-1:0]        fe_data_out,
    input  logic                         fe_ss_pos_edge,
    input  logic                         fe_ss_neg_edge,
    output logic [SPI_DATA_W-1:0]        fe_data_in,
    output logic                         bus_valid,
    output logic                         bus_we,
    output logic [ADDR_W-1:0]            bus_addr,
    output logic [SPI_DATA_W-ADDR_W-2:0] bus_wdata,
    input  logic                         bus_ready,
    input  logic [SPI_DATA_W-ADDR_W-2:0] bus_rdata,
    output logic                         busy,
    output logic                         err,
    output logic [7:0]                   overrun_cnt
);

    localparam int DW = SPI_DATA_W - 1 - ADDR_W;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        REQ   = 2'd2
    } state_t;

    state_t                  state_r, state_s;
    logic [CW-1:0]           cnt_r, cnt_s;
    logic [SPI_DATA_W-1:0]   cmd_r, cmd_s;
    logic [SPI_DATA_W-1:0]   resp_r, resp_s;
    logic                    err_r, err_s;
    logic [7:0]              ovr_r, ovr_s;
    logic                    valid_r, busy_r;

    // State register and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            cmd_r   <= '0;
            resp_r  <= '0;
            err_r   <= 1'b0;
            ovr_r   <= 8'd0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            cmd_r   <= cmd_s;
            resp_r  <= resp_s;
            err_r   <= err_s;
            ovr_r   <= ovr_s;
            valid_r <= (state_s == REQ);
            busy_r  <= (state_s != IDLE);
        end
    end

    // Next-state, command capture, response build, timeout and overrun accounting
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        cmd_s   = cmd_r;
        resp_s  = resp_r;
        err_s   = err_r;
        ovr_s   = ovr_r;
        case (state_r)
            IDLE: begin
                if (fe_ss_neg_edge) begin
                    state_s = FRAME;
                end else begin
                    state_s = IDLE;
                end
            end
            FRAME: begin
                if (fe_ss_pos_edge) begin
                    cmd_s   = fe_data_out;
                    cnt_s   = '0;
                    state_s = REQ;
                end else begin
                    state_s = FRAME;
                end
            end
            REQ: begin
                // A frame starting mid-access is dropped, never re-entering FRAME
                if (fe_ss_neg_edge && (ovr_r != 8'hFF)) begin
                    ovr_s = ovr_r + 8'd1;
                end else begin
                    ovr_s = ovr_r;
                end
                cnt_s = cnt_r + CW'(1);
                if (bus_ready) begin
                    resp_s  = {1'b0, cmd_r[SPI_DATA_W-2:DW],
                               cmd_r[SPI_DATA_W-1] ? cmd_r[DW-1:0] : bus_rdata};
                    state_s = IDLE;
                end else if (cnt_r == TO_LAST) begin
                    resp_s  = {1'b1, cmd_r[SPI_DATA_W-2:DW], {DW{1'b0}}};
                    err_s   = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = REQ;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign fe_data_in  = resp_r;
    assign bus_valid   = valid_r;
    assign busy        = busy_r;
    assign err         = err_r;
    assign overrun_cnt = ovr_r;
    assign bus_we      = cmd_r[SPI_DATA_W-1];
    assign bus_addr    = cmd_r[SPI_DATA_W-2:DW];
    assign bus_wdata   = cmd_r[DW-1:0];

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed self-checking bench for spi_slave_ctrl (TIMEOUT overridden to 4).
module tb_spi_slave_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] fe_data_out = 32'd0;
    logic        fe_ss_pos_edge = 1'b0;
    logic        fe_ss_neg_edge = 1'b0;
    logic [31:0] fe_data_in;
    logic        bus_valid, bus_we;
    logic [6:0]  bus_addr;
    logic [23:0] bus_wdata;
    logic        bus_ready = 1'b0;
    logic [23:0] bus_rdata = 24'd0;
    logic        busy, err;
    logic [7:0]  overrun_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    spi_slave_ctrl #(.SPI_DATA_W(32), .ADDR_W(7), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .fe_data_out(fe_data_out), .fe_ss_pos_edge(fe_ss_pos_edge),
        .fe_ss_neg_edge(fe_ss_neg_edge), .fe_data_in(fe_data_in),
        .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
        .busy(busy), .err(err), .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full SPI frame; returns in the first cycle the request should be visible.
    task automatic frame(input logic [31:0] w, input logic [31:0] hold, input bit do_chk);
        fe_ss_neg_edge = 1'b1;
        step();
        fe_ss_neg_edge = 1'b0;
        step();
        if (do_chk) begin
            chk("frame_hold", fe_data_in, hold);
            chk("frame_busy", {31'd0, busy}, 32'd1);
        end
        fe_data_out    = w;
        fe_ss_pos_edge = 1'b1;
        step();
        fe_ss_pos_edge = 1'b0;
    endtask

    initial begin
        step();
        step();
        chk("rst_valid", {31'd0, bus_valid}, 32'd0);
        chk("rst_data_in", fe_data_in, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_ovr", {24'd0, overrun_cnt}, 32'd0);
        chk("rst_addr", {25'd0, bus_addr}, 32'd0);
        rst = 1'b0;
        step();

        // Write with ready on the third request cycle
        frame(32'h85123456, 32'd0, 1'b1);
        chk("wr_valid", {31'd0, bus_valid}, 32'd1);
        chk("wr_we", {31'd0, bus_we}, 32'd1);
        chk("wr_addr", {25'd0, bus_addr}, 32'h05);
        chk("wr_wdata", {8'd0, bus_wdata}, 32'h123456);
        step();
        step();
        chk("wr_valid_wait", {31'd0, bus_valid}, 32'd1);
        bus_ready = 1'b1;
        step();
        bus_ready = 1'b0;
        chk("wr_valid_done", {31'd0, bus_valid}, 32'd0);
        chk("wr_resp", fe_data_in, 32'h05123456);
        chk("wr_busy_done", {31'd0, busy}, 32'd0);
        chk("wr_addr_hold", {25'd0, bus_addr}, 32'h05);

        // Zero-wait read
        frame(32'h0A000000, 32'h05123456, 1'b1);
        chk("rd_valid", {31'd0, bus_valid}, 32'd1);
        chk("rd_we", {31'd0, bus_we}, 32'd0);
        bus_ready = 1'b1;
        bus_rdata = 24'hABCDEF;
        step();
        bus_ready = 1'b0;
        chk("rd_valid_done", {31'd0, bus_valid}, 32'd0);
        chk("rd_resp", fe_data_in, 32'h0AABCDEF);
        chk("rd_err", {31'd0, err}, 32'd0);

        // Timeout: valid high exactly 4 cycles
        frame(32'h11000000, 32'h0AABCDEF, 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk("to_valid_hi", {31'd0, bus_valid}, 32'd1);
            chk("to_err_lo", {31'd0, err}, 32'd0);
            step();
        end
        chk("to_valid_lo", {31'd0, bus_valid}, 32'd0);
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_resp", fe_data_in, 32'h91000000);

        // Overrun: new frame during REQ is dropped
        frame(32'h0A000001, 32'h91000000, 1'b1);
        fe_ss_neg_edge = 1'b1;
        step();
        fe_ss_neg_edge = 1'b0;
        chk("ov_cnt", {24'd0, overrun_cnt}, 32'd1);
        chk("ov_valid", {31'd0, bus_valid}, 32'd1);
        fe_data_out    = 32'h85FFFFFF;
        fe_ss_pos_edge = 1'b1;
        step();
        fe_ss_pos_edge = 1'b0;
        chk("ov_addr_stable", {25'd0, bus_addr}, 32'h0A);
        bus_ready = 1'b1;
        bus_rdata = 24'h000055;
        step();
        bus_ready = 1'b0;
        chk("ov_resp", fe_data_in, 32'h0A000055);
        step();
        step();
        chk("ov_single", {31'd0, bus_valid}, 32'd0);
        chk("ov_idle", {31'd0, busy}, 32'd0);

        // Simultaneous neg edge and ready
        frame(32'h85000777, 32'h0A000055, 1'b1);
        fe_ss_neg_edge = 1'b1;
        bus_ready      = 1'b1;
        step();
        fe_ss_neg_edge = 1'b0;
        bus_ready      = 1'b0;
        chk("sim_valid", {31'd0, bus_valid}, 32'd0);
        chk("sim_cnt", {24'd0, overrun_cnt}, 32'd2);
        chk("sim_resp", fe_data_in, 32'h05000777);
        fe_data_out    = 32'h8F0000AA;
        fe_ss_pos_edge = 1'b1;
        step();
        fe_ss_pos_edge = 1'b0;
        chk("sim_nopos", {31'd0, bus_valid}, 32'd0);
        step();
        chk("sim_nopos2", {31'd0, busy}, 32'd0);

        // Saturation: 254 more overruns make 256 total
        bus_rdata = 24'd0;
        for (int i = 0; i < 254; i++) begin
            frame(32'h01000000, 32'd0, 1'b0);
            fe_ss_neg_edge = 1'b1;
            bus_ready      = 1'b1;
            step();
            fe_ss_neg_edge = 1'b0;
            bus_ready      = 1'b0;
            if (i == 252) chk("sat_254", {24'd0, overrun_cnt}, 32'd255);
        end
        chk("sat_cnt", {24'd0, overrun_cnt}, 32'd255);
        chk("sat_resp", fe_data_in, 32'h01000000);

        // Async reset mid-request
        frame(32'h85ABCDEF, 32'h01000000, 1'b1);
        chk("ar_valid_pre", {31'd0, bus_valid}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("ar_valid", {31'd0, bus_valid}, 32'd0);
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_err", {31'd0, err}, 32'd0);
        chk("ar_ovr", {24'd0, overrun_cnt}, 32'd0);
        chk("ar_data_in", fe_data_in, 32'd0);
        chk("ar_addr", {25'd0, bus_addr}, 32'd0);
        chk("ar_we", {31'd0, bus_we}, 32'd0);
        step();
        rst = 1'b0;
        step();
        frame(32'h0A000000, 32'd0, 1'b1);
        chk("ar2_valid", {31'd0, bus_valid}, 32'd1);
        bus_ready = 1'b1;
        bus_rdata = 24'h123456;
        step();
        bus_ready = 1'b0;
        chk("ar2_resp", fe_data_in, 32'h0A123456);
        chk("ar2_err", {31'd0, err}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_ctrl.md
# spi_slave_ctrl

SPI slave transaction controller; sits directly downstream of the SPI front end and consumes its parallel word and slave-select edge strobes. Each completed SPI frame is one command word: write flag, register address and write payload. The block turns that word into a single valid/ready bus access and loads the response word back into the front end's `data_in`, so the master shifts it out on MISO during the next frame. It also provides a bus timeout, a frame-overrun counter and a busy flag.

## Interface
- `SPI_DATA_W`, 32: SPI frame width; must equal the front end's `SPI_DATA_W`.
- `ADDR_W`, 7: register address width.
- `TIMEOUT`, 255: maximum bus wait in cycles, ≥1; counter width = clog2(TIMEOUT+1).
- Derived (not a parameter): `DW` = `SPI_DATA_W`-1-`ADDR_W` (24 by default) = bus data width.
- `clk` in 1: system clock; the only clock.
- `rst` in 1: reset, asynchronous, active-high.
- `fe_data_out` in `SPI_DATA_W`: received word from the front end; valid when `fe_ss_pos_edge` is high.
- `fe_ss_pos_edge` in 1: one-cycle strobe at end of frame.
- `fe_ss_neg_edge` in 1: one-cycle strobe at start of frame.
- `fe_data_in` out `SPI_DATA_W`: response word shifted out during the next frame.
- `bus_valid` out 1: bus request.
- `bus_we` out 1: 1 = write, 0 = read.
- `bus_addr` out `ADDR_W`: bus address.
- `bus_wdata` out `DW`: write data.
- `bus_ready` in 1: bus completion; sampled only while `bus_valid` is high.
- `bus_rdata` in `DW`: read data; valid with `bus_ready`.
- `busy` out 1: high in any state other than IDLE.
- `err` out 1: sticky timeout flag; cleared only by reset.
- `overrun_cnt` out 8: count of dropped frames; saturates at 255.

## Operation
- Command word fields:
  - bit [`SPI_DATA_W`-1] = we.
  - bits [`SPI_DATA_W`-2:`DW`] = addr.
  - bits [`DW`-1:0] = wdata (ignored for reads).
- Response word = {status, addr, data}:
  - status = 0 on success, 1 on timeout.
  - addr = address of the completed command.
  - data = read data for reads, echoed wdata for writes, 0 on timeout.
- States:
  - IDLE: on `fe_ss_neg_edge` → FRAME. A `fe_ss_pos_edge` seen in IDLE is ignored.
  - FRAME: on `fe_ss_pos_edge`, latch `fe_data_out` into the command register → REQ. A repeated `fe_ss_neg_edge` keeps the state in FRAME.
  - REQ: `bus_valid`=1 and the timeout counter increments each cycle. `bus_valid`&`bus_ready` → capture response into `fe_data_in` → IDLE. If the counter reaches `TIMEOUT` with no ready → timeout response, set `err` → IDLE.
- Overrun:
  - Any `fe_ss_neg_edge` while in REQ increments `overrun_cnt` (saturating).
  - That frame is dropped: its `fe_ss_pos_edge` is ignored and the state does not re-enter FRAME.
  - The master receives whatever `fe_data_in` held when that frame started.
- If `fe_ss_neg_edge` and `bus_ready` occur in the same REQ cycle: the bus completes normally, the overrun is counted and the state goes to IDLE, so the frame's later pos edge is ignored.
- `bus_we`, `bus_addr` and `bus_wdata` are driven from the command register, stable for the whole of REQ. Outside REQ they hold their last values.
- `fe_data_in` changes only on leaving REQ; it never changes during FRAME.

## Timing
- Reset values:
  - State = IDLE.
  - `bus_valid`, `bus_we` = 0.
  - `bus_addr`, `bus_wdata` = 0.
  - `fe_data_in` = 0.
  - `busy`, `err` = 0.
  - `overrun_cnt` = 0.
  - Timeout counter = 0.
- `fe_ss_pos_edge` in cycle N → `bus_valid`=1 from cycle N+1 (registered).
- `bus_ready` in cycle M → `bus_valid`=0 and `fe_data_in` updated in cycle M+1. Zero-wait bus: N+1 valid, N+1 ready, N+2 idle.
- Timeout: the counter clears on entering REQ. With no ready, `bus_valid` stays high for exactly `TIMEOUT` cycles, then drops on the next edge; `err` rises in that same cycle.
- `rst` asserted mid-REQ: `bus_valid` drops asynchronously and the transaction is lost; no response is written.

## Test plan
- Write: frame 0x85_123456 (we=1, addr=0x05) → one `bus_valid` pulse with we=1, addr=0x05, wdata=0x123456; with ready after 3 cycles, `fe_data_in`=0x05_123456.
- Read: frame 0x0A_000000; `bus_rdata`=0xABCDEF with zero wait → `bus_valid` high exactly 1 cycle, `fe_data_in`=0x0AABCDEF, `err`=0.
- Timeout (`TIMEOUT`=4): read addr 0x11 with ready never asserted → `bus_valid` high for 4 cycles, `err`=1, `fe_data_in`=0x91000000.
- Overrun: new frame starts while ready is held low → `overrun_cnt`=1, frame ignored, single bus access; 256 overruns → `overrun_cnt` stays at 255.
- Simultaneous `fe_ss_neg_edge` and `bus_ready`: access completes, `overrun_cnt`+1, the following pos edge creates no request.
- Async `rst` mid-REQ → all outputs at reset values immediately; the next frame works normally.
